rrns_enc_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one encoder_3nrm instance among NUM_REQ requesters.

---
 rtl/rrns_enc_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rrns_enc_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrns_enc_arbiter.sv
// Round-robin sequencer sharing one RRNS encoder among NUM_REQ requesters.
// Latency: accept A, enc_start A+1, result A+3 with a 1-cycle encoder; 1 result per 4 cycles.
// Backpressure: one job in flight; req_ready only in IDLE; result held until res_ready.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_data/req_ready  per-requester valid/ready input, 16-bit word each
//   enc_start/enc_data_in         start pulse and held operand towards the encoder
//   enc_residues/enc_done         encoder result and its valid strobe
//   res_valid/res_ready           result handshake
//   res_residues/res_id/res_err   captured residues, owning requester, timeout flag
//   busy, timeout_count           state != IDLE, saturating timeout counter
module rrns_enc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  enc_start,
    output logic [15:0]           enc_data_in,
    input  logic [63:0]           enc_residues,
    input  logic                  enc_done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [63:0]           res_residues,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_err,
    output logic                  busy,
    output logic [7:0]            timeout_count
);

    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [15:0]       data_q;
    logic [TMR_W-1:0]  timer;
    logic              timer_exp;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [15:0]       grant_data;

    // (base + k) mod NUM_REQ; both operands are below NUM_REQ so one wrap suffices.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid[wrap_add(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_ptr, k);
            end
        end
    end

    assign grant_data = req_data[16*grant_idx +: 16];
    assign timer_exp  = (timer == TMR_W'(TIMEOUT - 1));

    // req_ready is combinational from req_valid; gating with rst_n keeps every
    // output low while reset is asserted even if requesters are already valid.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && grant_vld && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // enc_done is only looked at in WAIT, so a stray or late done is harmless.
    // In WAIT a done in the expiry cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (enc_done || timer_exp) state_nxt = ST_OUT;
            ST_OUT:   if (res_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign enc_start   = (state == ST_ISSUE);
    assign res_valid   = (state == ST_OUT);
    assign busy        = (state != ST_IDLE);
    assign enc_data_in = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            data_q        <= '0;
            timer         <= '0;
            res_residues  <= '0;
            res_id        <= '0;
            res_err       <= 1'b0;
            timeout_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        data_q <= grant_data;
                        res_id <= grant_idx;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                end
                ST_WAIT: begin
                    if (enc_done) begin
                        res_residues <= enc_residues;
                        res_err      <= 1'b0;
                    end else if (timer_exp) begin
                        res_residues <= '0;
                        res_err      <= 1'b1;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_OUT: begin
                    // Fairness: the requester just served goes to the back of the ring.
                    if (res_ready) begin
                        rr_ptr <= wrap_add(res_id, 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rrns_enc_arbiter.sv
module tb_rrns_enc_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 15;

    localparam logic [63:0] LIT100   = {6'd36, 6'd37, 7'd35, 5'd7, 5'd13, 5'd8, 5'd5, 5'd15, 20'd0};
    localparam logic [63:0] LIT65535 = {6'd63, 6'd15, 7'd15, 5'd1, 5'd24, 5'd8, 5'd4, 5'd0, 20'd0};
    localparam logic [63:0] LIT64    = {6'd0, 6'd1, 7'd64, 5'd2, 5'd6, 5'd18, 5'd7, 5'd13, 20'd0};
    localparam logic [63:0] LIT500   = {6'd52, 6'd59, 7'd45, 5'd4, 5'd7, 5'd17, 5'd6, 5'd7, 20'd0};
    localparam logic [63:0] LIT9     = {6'd9, 6'd9, 7'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 20'd0};
    localparam logic [63:0] FORCE_RES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  enc_start;
    logic [15:0]           enc_data_in;
    logic [63:0]           enc_residues;
    logic                  enc_done;
    logic                  res_valid;
    logic                  res_ready;
    logic [63:0]           res_residues;
    logic [ID_W-1:0]       res_id;
    logic                  res_err;
    logic                  busy;
    logic [7:0]            timeout_count;

    always #5 clk = ~clk;

    rrns_enc_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .enc_start(enc_start), .enc_data_in(enc_data_in),
        .enc_residues(enc_residues), .enc_done(enc_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_residues(res_residues), .res_id(res_id), .res_err(res_err),
        .busy(busy), .timeout_count(timeout_count)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    endtask

    function automatic logic [63:0] rrns(input int x);
        return {6'(x % 64), 6'(x % 63), 7'(x % 65), 5'(x % 31), 5'(x % 29),
                5'(x % 23), 5'(x % 19), 5'(x % 17), 20'd0};
    endfunction

    // ---------------- requesters: hold valid/data until accepted ----------------
    logic [15:0]        rq [NUM_REQ][$];
    logic [NUM_REQ-1:0] acc_mask;

    always @(negedge clk) acc_mask = req_valid & req_ready;

    initial begin
        req_valid = '0;
        req_data  = '0;
        acc_mask  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() > 0);
                req_data[16*i +: 16] = (rq[i].size() > 0) ? rq[i][0] : 16'h0;
            end
        end
    end

    // ---------------- encoder: done enc_delay cycles after start, or stuck ----------------
    logic        stuck;
    int          enc_delay;
    logic        model_done;
    logic [63:0] model_res;
    logic        force_done;
    logic        enc_pend;
    int          enc_cnt;
    logic [15:0] enc_op;

    assign enc_done     = model_done | force_done;
    assign enc_residues = force_done ? FORCE_RES : model_res;

    initial begin
        model_done = 1'b0;
        model_res  = '0;
        enc_pend   = 1'b0;
        enc_cnt    = 0;
        enc_op     = '0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (!rst_n) begin
                enc_pend = 1'b0;
            end else begin
                if (enc_pend) begin
                    enc_cnt++;
                    if (!stuck && enc_cnt == enc_delay) begin
                        model_done = 1'b1;
                        model_res  = rrns(int'(enc_op));
                        enc_pend   = 1'b0;
                    end
                end
                if (enc_start) begin
                    enc_pend = 1'b1;
                    enc_cnt  = 0;
                    enc_op   = enc_data_in;
                end
            end
        end
    end

    // ---------------- transaction-level reference model + compare ----------------
    typedef struct {
        int          id;
        logic        err;
        logic [63:0] res;
        int          acc;
        int          vld;
    } rec_t;

    rec_t        log_q[$];
    bit          m_busy = 0;
    bit          m_have = 0;
    int          m_ptr = 0, m_id = 0, m_acc = 0, m_res_cyc = 0, m_tcnt = 0;
    logic [15:0] m_data = '0;
    logic [63:0] m_res = '0;
    logic        m_err = 1'b0;
    int          cmp_g;
    logic [NUM_REQ-1:0] cmp_rdy;

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_enc_start", enc_start, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_res_residues", res_residues, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_err", res_err, 0);
            chk("rst_timeout_count", timeout_count, 0);
            chk("rst_enc_data_in", enc_data_in, 0);
            m_busy = 0; m_have = 0; m_ptr = 0; m_tcnt = 0;
        end else begin
            cmp_g   = m_busy ? -1 : pick(req_valid, m_ptr);
            cmp_rdy = '0;
            if (cmp_g >= 0) cmp_rdy[cmp_g] = 1'b1;
            chk("req_ready", req_ready, cmp_rdy);
            chk("enc_start", enc_start, m_busy && (cyc == m_acc + 1));
            chk("res_valid", res_valid, m_have);
            chk("busy", busy, m_busy);
            chk("timeout_count", timeout_count, 8'(m_tcnt));
            if (m_busy) chk("enc_data_in", enc_data_in, m_data);
            if (m_have) begin
                chk("res_id", res_id, m_id);
                chk("res_err", res_err, m_err);
                chk("res_residues", res_residues, m_res);
            end
            // Advance with this cycle's inputs.
            if (!m_busy) begin
                if (cmp_g >= 0) begin
                    m_busy = 1; m_have = 0; m_acc = cyc; m_id = cmp_g;
                    m_data = req_data[16*cmp_g +: 16];
                end
            end else if (!m_have) begin
                if (cyc >= m_acc + 2 && enc_done) begin
                    m_have = 1; m_err = 0; m_res = rrns(int'(m_data)); m_res_cyc = cyc + 1;
                end else if (cyc == m_acc + 1 + TIMEOUT) begin
                    m_have = 1; m_err = 1; m_res = '0; m_res_cyc = cyc + 1;
                    if (m_tcnt < 255) m_tcnt++;
                end
            end else if (res_ready) begin
                log_q.push_back('{id: m_id, err: m_err, res: m_res, acc: m_acc, vld: m_res_cyc});
                m_busy = 0; m_have = 0;
                m_ptr = (m_id + 1) % NUM_REQ;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_results(input int n, input int budget, input string nm);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk({nm, "_results_arrived"}, log_q.size() >= n, 1);
    endtask

    function automatic rec_t rec_at(input int i);
        rec_t r;
        r.id = -1; r.err = 1'bx; r.res = 'x; r.acc = 0; r.vld = -1000;
        if (i < log_q.size()) r = log_q[i];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   k;
        rec_t r;
        rst_n = 1'b1; res_ready = 1'b1; force_done = 1'b0; stuck = 1'b0; enc_delay = 1;
        #2 rst_n = 1'b0;
        tick(3);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_timeout_count", timeout_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Single request, 1-cycle encoder.
        base = log_q.size();
        rq[0].push_back(16'd100);
        wait_results(base + 1, 40, "t1");
        r = rec_at(base);
        chk("t1_id", r.id, 0);
        chk("t1_err", r.err, 0);
        chk("t1_res", r.res, LIT100);
        chk("t1_latency", r.vld - r.acc, 3);

        // Fresh ring: all four requesters contend.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        base = log_q.size();
        rq[0].push_back(16'd0);
        rq[0].push_back(16'd1000);
        rq[1].push_back(16'd65535);
        rq[2].push_back(16'd64);
        rq[3].push_back(16'd63);
        wait_results(base + 5, 80, "t2");
        chk("t2_id0", rec_at(base).id, 0);
        chk("t2_id1", rec_at(base + 1).id, 1);
        chk("t2_id2", rec_at(base + 2).id, 2);
        chk("t2_id3", rec_at(base + 3).id, 3);
        chk("t2_id4", rec_at(base + 4).id, 0);
        chk("t2_res_0", rec_at(base).res, 64'd0);
        chk("t2_res_65535", rec_at(base + 1).res, LIT65535);
        chk("t2_res_64", rec_at(base + 2).res, LIT64);
        for (int i = 0; i < 4; i++) begin
            chk("t2_accept_spacing", rec_at(base + i + 1).acc - rec_at(base + i).acc, 4);
        end

        // Result backpressure with a competing request and a stray done.
        res_ready = 1'b0;
        base = log_q.size();
        rq[2].push_back(16'd500);
        k = 0;
        while (!res_valid && k < 40) begin
            tick(1);
            k++;
        end
        chk("t3_valid_seen", res_valid, 1);
        rq[0].push_back(16'd7);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_id", res_id, 2);
            chk("t3_hold_res", res_residues, LIT500);
            chk("t3_hold_req_ready", req_ready, 0);
            force_done = (i == 4);
            tick(1);
        end
        force_done = 1'b0;
        res_ready  = 1'b1;
        wait_results(base + 2, 40, "t3");
        chk("t3_id", rec_at(base).id, 2);
        chk("t3_res", rec_at(base).res, LIT500);
        chk("t3_next_id", rec_at(base + 1).id, 0);

        // Encoder never answers.
        stuck = 1'b1;
        base = log_q.size();
        rq[1].push_back(16'd1234);
        wait_results(base + 1, 60, "t4");
        r = rec_at(base);
        chk("t4_id", r.id, 1);
        chk("t4_err", r.err, 1);
        chk("t4_res", r.res, 64'd0);
        chk("t4_latency", r.vld - r.acc, 17);
        chk("t4_timeout_count", timeout_count, 1);
        stuck = 1'b0;
        rq[3].push_back(16'd9);
        wait_results(base + 2, 40, "t4b");
        chk("t4b_id", rec_at(base + 1).id, 3);
        chk("t4b_err", rec_at(base + 1).err, 0);
        chk("t4b_res", rec_at(base + 1).res, LIT9);

        // Done lands in the expiry cycle.
        enc_delay = 15;
        base = log_q.size();
        rq[0].push_back(16'd100);
        wait_results(base + 1, 60, "t6");
        r = rec_at(base);
        chk("t6_id", r.id, 0);
        chk("t6_err", r.err, 0);
        chk("t6_res", r.res, LIT100);
        chk("t6_latency", r.vld - r.acc, 17);
        chk("t6_timeout_count", timeout_count, 1);
        enc_delay = 1;

        // Reset in WAIT, then a late done.
        stuck = 1'b1;
        rq[2].push_back(16'd42);
        k = 0;
        while (!busy && k < 20) begin
            tick(1);
            k++;
        end
        tick(4);
        chk("t5_in_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_enc_start", enc_start, 0);
        chk("t5_async_res_valid", res_valid, 0);
        chk("t5_async_req_ready", req_ready, 0);
        chk("t5_async_timeout_count", timeout_count, 0);
        chk("t5_async_enc_data_in", enc_data_in, 0);
        chk("t5_async_res_id", res_id, 0);
        chk("t5_async_res_residues", res_residues, 0);
        tick(2);
        rst_n = 1'b1;
        stuck = 1'b0;
        tick(1);
        force_done = 1'b1;
        tick(1);
        force_done = 1'b0;
        tick(1);
        chk("t5_late_done_busy", busy, 0);
        chk("t5_late_done_valid", res_valid, 0);
        base = log_q.size();
        rq[3].push_back(16'd11);
        rq[1].push_back(16'd12);
        rq[0].push_back(16'd13);
        wait_results(base + 3, 60, "t5");
        chk("t5_first_id", rec_at(base).id, 0);
        chk("t5_second_id", rec_at(base + 1).id, 1);
        chk("t5_third_id", rec_at(base + 2).id, 3);
        chk("t5_first_err", rec_at(base).err, 0);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
